// File: rtl/window_stream_ctrl.sv
// Frame sequencer: feeds one RGB frame plus IMG_W+1 flush pixels into the 3x3 window
// generator and tags each returned window with its centre coordinates. Optional macro WSC_TIMEOUT_EN adds a DRAIN watchdog.
module window_stream_ctrl #(
    parameter int IMG_W         = 640,
    parameter int IMG_H         = 480,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      frame_err,
    input  logic [23:0]               s_pixel,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [23:0]               wg_pixel,
    output logic                      wg_valid,
    input  logic                      wg_out_valid,
    output logic                      win_valid,
    output logic [$clog2(IMG_W)-1:0]  win_col,
    output logic [$clog2(IMG_H)-1:0]  win_row,
    output logic                      win_border
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int FL_W  = $clog2(IMG_W + 2);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [FL_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [CW-1:0]      tag_col_q, tag_col_d;
    logic [RW-1:0]      tag_row_q, tag_row_d;
    logic [23:0]        wg_pixel_q, wg_pixel_d;
    logic               wg_valid_q, wg_valid_d;
    logic               win_valid_q, win_valid_d;
    logic [CW-1:0]      win_col_q, win_col_d;
    logic [RW-1:0]      win_row_q, win_row_d;
    logic               win_border_q, win_border_d;
    logic               done_q, done_d;
    logic               frame_err_q, frame_err_d;

    logic start_ok, handshake, feed_last, flush_last;
    logic win_ok, win_extra, win_full_next, to_expire;

    // A start landing on the done cycle is dropped; it must be reissued in IDLE.
    assign start_ok   = (state_q == S_IDLE) && start && !done_q;
    assign handshake  = (state_q == S_FEED) && s_valid;
    assign feed_last  = handshake && (in_cnt_q == CNT_W'(NPIX - 1));
    assign flush_last = (state_q == S_FLUSH) && (flush_cnt_q == FL_W'(IMG_W));
    assign win_ok     = wg_out_valid && (state_q != S_IDLE) && (win_cnt_q != CNT_W'(NPIX));
    assign win_extra  = wg_out_valid && !win_ok;
    assign win_full_next = (win_cnt_q == CNT_W'(NPIX)) ||
                           (win_ok && (win_cnt_q == CNT_W'(NPIX - 1)));

`ifdef WSC_TIMEOUT_EN
    localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d  = '0;
        to_expire = 1'b0;
        if (state_q == S_DRAIN && !wg_out_valid) begin
            to_cnt_d  = to_cnt_q + TO_W'(1);
            to_expire = (to_cnt_d == TO_W'(DRAIN_TIMEOUT));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`else
    assign to_expire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE:  if (start_ok)   state_d = S_FEED;
            S_FEED:  if (feed_last)  state_d = S_FLUSH;
            S_FLUSH: if (flush_last) state_d = S_DRAIN;
            S_DRAIN: begin
                if (win_full_next || to_expire) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy    = (state_q != S_IDLE);
        s_ready = (state_q == S_FEED);
    end

    // Counters, pixel path and window tagging
    always_comb begin
        in_cnt_d     = in_cnt_q;
        win_cnt_d    = win_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        tag_col_d    = tag_col_q;
        tag_row_d    = tag_row_q;
        wg_pixel_d   = wg_pixel_q;
        wg_valid_d   = 1'b0;
        win_valid_d  = 1'b0;
        win_col_d    = win_col_q;
        win_row_d    = win_row_q;
        win_border_d = win_border_q;
        frame_err_d  = frame_err_q;

        if (start_ok) begin
            in_cnt_d    = '0;
            win_cnt_d   = '0;
            flush_cnt_d = '0;
            tag_col_d   = '0;
            tag_row_d   = '0;
            frame_err_d = 1'b0;
        end

        if (handshake) begin
            wg_pixel_d = s_pixel;
            wg_valid_d = 1'b1;
            in_cnt_d   = in_cnt_q + CNT_W'(1);
        end

        if (state_q == S_FLUSH) begin
            wg_pixel_d  = '0;
            wg_valid_d  = 1'b1;
            flush_cnt_d = flush_cnt_q + FL_W'(1);
        end

        // Coordinates advance as wrap counters so no divider is needed.
        if (win_ok) begin
            win_valid_d  = 1'b1;
            win_col_d    = tag_col_q;
            win_row_d    = tag_row_q;
            win_border_d = (tag_col_q == '0) || (tag_col_q == CW'(IMG_W - 1)) ||
                           (tag_row_q == '0) || (tag_row_q == RW'(IMG_H - 1));
            win_cnt_d    = win_cnt_q + CNT_W'(1);
            if (tag_col_q == CW'(IMG_W - 1)) begin
                tag_col_d = '0;
                tag_row_d = (tag_row_q == RW'(IMG_H - 1)) ? '0 : tag_row_q + RW'(1);
            end else begin
                tag_col_d = tag_col_q + CW'(1);
            end
        end

        if (win_extra || to_expire) frame_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt_q     <= '0;
            win_cnt_q    <= '0;
            flush_cnt_q  <= '0;
            tag_col_q    <= '0;
            tag_row_q    <= '0;
            wg_pixel_q   <= '0;
            wg_valid_q   <= 1'b0;
            win_valid_q  <= 1'b0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            win_border_q <= 1'b0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            in_cnt_q     <= in_cnt_d;
            win_cnt_q    <= win_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            tag_col_q    <= tag_col_d;
            tag_row_q    <= tag_row_d;
            wg_pixel_q   <= wg_pixel_d;
            wg_valid_q   <= wg_valid_d;
            win_valid_q  <= win_valid_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
            win_border_q <= win_border_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign wg_pixel   = wg_pixel_q;
    assign wg_valid   = wg_valid_q;
    assign win_valid  = win_valid_q;
    assign win_col    = win_col_q;
    assign win_row    = win_row_q;
    assign win_border = win_border_q;
    assign done       = done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_window_stream_ctrl.sv
// Randomised bench for window_stream_ctrl on a 4x3 frame: a count-based frame model
// predicts every output each cycle, and literal tables pin the model's pixel/tag order.
module tb_window_stream_ctrl;

    localparam int W = 4, H = 3, NPIX = W * H, TO = 16;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic        s_valid = 1'b0, wg_out_valid = 1'b0;
    logic [23:0] s_pixel = '0;
    logic        busy, done, frame_err, s_ready, wg_valid, win_valid, win_border;
    logic [23:0] wg_pixel;
    logic [1:0]  win_col, win_row;

    window_stream_ctrl #(.IMG_W(W), .IMG_H(H), .DRAIN_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .frame_err(frame_err), .s_pixel(s_pixel), .s_valid(s_valid),
        .s_ready(s_ready), .wg_pixel(wg_pixel), .wg_valid(wg_valid),
        .wg_out_valid(wg_out_valid), .win_valid(win_valid), .win_col(win_col),
        .win_row(win_row), .win_border(win_border)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0, cyc = 0;

    // Frame model: progress expressed as counts of accepted pixels, flush pixels and windows.
    bit          m_active, m_err;
    int          m_acc, m_fl, m_wins, m_idle;
    bit          e_done, e_wg_valid, e_win_valid, e_bd;
    logic [23:0] e_pix;
    int          e_col, e_row;

    int cap_pix[$], cap_col[$], cap_row[$], cap_bd[$];
    int done_cnt = 0, done_cyc = -1, last_win_cyc = -1;

    int exp_pix[17] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 0, 0, 0, 0, 0};
    int exp_col[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int exp_row[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    int exp_bd[12]  = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit prev_done, feed, flush, drain;
        if (rst) begin
            m_active = 0; m_err = 0; m_acc = 0; m_fl = 0; m_wins = 0; m_idle = 0;
            e_done = 0; e_wg_valid = 0; e_win_valid = 0; e_pix = '0;
            e_col = 0; e_row = 0; e_bd = 0;
            return;
        end
        prev_done   = e_done;
        e_done      = 0;
        e_wg_valid  = 0;
        e_win_valid = 0;
        if (!m_active) begin
            if (start && !prev_done) begin
                m_active = 1; m_acc = 0; m_fl = 0; m_wins = 0; m_idle = 0; m_err = 0;
            end
            if (wg_out_valid) m_err = 1;
        end else begin
            feed  = (m_acc < NPIX);
            flush = !feed && (m_fl < W + 1);
            drain = !feed && !flush;
            if (feed && s_valid) begin
                e_wg_valid = 1; e_pix = s_pixel; m_acc++;
            end else if (flush) begin
                e_wg_valid = 1; e_pix = '0; m_fl++;
            end
            if (wg_out_valid) begin
                if (m_wins < NPIX) begin
                    e_win_valid = 1;
                    e_col = m_wins % W;
                    e_row = m_wins / W;
                    e_bd  = (e_col == 0) || (e_col == W - 1) || (e_row == 0) || (e_row == H - 1);
                    m_wins++;
                end else begin
                    m_err = 1;
                end
            end
            if (drain) begin
                if (m_wins == NPIX) begin
                    m_active = 0; e_done = 1;
                end
`ifdef WSC_TIMEOUT_EN
                else begin
                    m_idle = wg_out_valid ? 0 : m_idle + 1;
                    if (m_idle == TO) begin
                        m_err = 1; m_active = 0; e_done = 1;
                    end
                end
`endif
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Per-cycle compare against the model, plus capture for the literal checks.
    initial forever begin
        @(negedge clk);
        cyc++;
        chk("busy", busy, m_active);
        chk("s_ready", s_ready, m_active && (m_acc < NPIX));
        chk("done", done, e_done);
        chk("frame_err", frame_err, m_err);
        chk("wg_valid", wg_valid, e_wg_valid);
        if (e_wg_valid) chk("wg_pixel", wg_pixel, e_pix);
        chk("win_valid", win_valid, e_win_valid);
        if (e_win_valid) begin
            chk("win_col", win_col, e_col);
            chk("win_row", win_row, e_row);
            chk("win_border", win_border, e_bd);
        end
        if (wg_valid) cap_pix.push_back(int'(wg_pixel));
        if (win_valid) begin
            cap_col.push_back(int'(win_col));
            cap_row.push_back(int'(win_row));
            cap_bd.push_back(int'(win_border));
            last_win_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic run_frame(input int vpct, input bit seq, input bit toggle, input int n_win,
                             input bit late, input int rst_at, input bit start_flush,
                             input bit rnd_start);
        int issued = 0, budget = 0, idle_after = 0;
        bit tog = 0, fs_done = 0, win_ok;
        cap_pix.delete(); cap_col.delete(); cap_row.delete(); cap_bd.delete();
        done_cnt = 0; done_cyc = -1; last_win_cyc = -1;
        @(negedge clk);
        start = 1;
        forever begin
            @(negedge clk);
            budget++;
            start = 0; s_valid = 0; wg_out_valid = 0;
            if (budget > 2000) begin
                n_vec++; n_bad++;
                $display("FAIL frame_budget: frame still active after %0d cycles", budget);
                return;
            end
            if (rst_at >= 0 && m_active && m_acc == rst_at) begin
                #1 rst = 1;
                @(negedge clk);
                chk("rst_busy", busy, 0);
                chk("rst_s_ready", s_ready, 0);
                chk("rst_wg_valid", wg_valid, 0);
                chk("rst_wg_pixel", wg_pixel, 0);
                chk("rst_win_valid", win_valid, 0);
                chk("rst_frame_err", frame_err, 0);
                rst = 0;
                return;
            end
            if (m_active && m_acc < NPIX) begin
                s_valid = toggle ? tog : ($urandom_range(99) < vpct);
                tog     = ~tog;
                s_pixel = seq ? 24'(m_acc + 1) : 24'($urandom);
            end else begin
                s_valid = 1'($urandom_range(1));
                s_pixel = 24'($urandom);
            end
            win_ok = m_active ? (!late || (m_acc == NPIX && m_fl == W + 1)) : (issued >= NPIX);
            if (issued < n_win && win_ok && $urandom_range(1) == 1) begin
                wg_out_valid = 1; issued++;
            end
            if (start_flush && !fs_done && m_active && m_acc == NPIX && m_fl == 2) begin
                start = 1; fs_done = 1;
            end
            if (rnd_start && (m_active || e_done) && $urandom_range(7) == 0) start = 1;
            if (!m_active && issued >= n_win) idle_after++;
            if (idle_after >= 3) break;
        end
        start = 0; s_valid = 0; wg_out_valid = 0;
    endtask

    task automatic check_literal_frame();
        chk("pix_count", cap_pix.size(), 17);
        for (int i = 0; i < cap_pix.size() && i < 17; i++) chk("pix_seq", cap_pix[i], exp_pix[i]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", frame_err, 0);
        chk("reset_s_ready", s_ready, 0);
        chk("reset_wg_valid", wg_valid, 0);
        chk("reset_wg_pixel", wg_pixel, 0);
        chk("reset_win_valid", win_valid, 0);
        chk("reset_win_col", win_col, 0);
        chk("reset_win_row", win_row, 0);
        chk("reset_win_border", win_border, 0);
        rst = 0;

        // Continuous pixels 1..12, windows only once draining.
        run_frame(100, 1, 0, 12, 1, -1, 0, 0);
        check_literal_frame();
        chk("win_count", cap_col.size(), 12);
        for (int i = 0; i < cap_col.size() && i < 12; i++) begin
            chk("tag_col", cap_col[i], exp_col[i]);
            chk("tag_row", cap_row[i], exp_row[i]);
            chk("tag_border", cap_bd[i], exp_bd[i]);
        end
        chk("done_count", done_cnt, 1);
        chk("done_gap", done_cyc - last_win_cyc, 0);
        chk("frame_err_clean", frame_err, 0);

        // s_valid toggling every other cycle.
        run_frame(0, 1, 1, 12, 0, -1, 0, 0);
        check_literal_frame();
        chk("toggle_done_count", done_cnt, 1);

        // Surplus 13th window.
        run_frame(100, 0, 0, 13, 0, -1, 0, 0);
        chk("surplus_win_count", cap_col.size(), 12);
        repeat (4) @(negedge clk);
        chk("err_sticky", frame_err, 1);

        // Start during FLUSH ignored; the accepted start clears the sticky error.
        run_frame(100, 0, 0, 12, 0, -1, 1, 0);
        chk("flush_start_done_count", done_cnt, 1);
        chk("err_cleared", frame_err, 0);

        // Reset after 6 handshakes, then a clean frame.
        run_frame(100, 0, 0, 12, 0, 6, 0, 0);
        run_frame(70, 0, 0, 12, 0, -1, 0, 0);
        chk("post_rst_done_count", done_cnt, 1);
        chk("post_rst_err", frame_err, 0);

        for (int f = 0; f < 6; f++) begin
            run_frame($urandom_range(100, 30), 0, 0, 12, 1'($urandom_range(1)), -1, 0, 1);
            chk("rand_done_count", done_cnt, 1);
        end

`ifdef WSC_TIMEOUT_EN
        run_frame(100, 0, 0, 10, 1, -1, 0, 0);
        chk("to_done_count", done_cnt, 1);
        chk("to_gap", done_cyc - last_win_cyc, TO);
        chk("to_err", frame_err, 1);
        chk("to_idle", busy, 0);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/window_stream_ctrl.md
# window_stream_ctrl

Frame sequencer for the 3x3 window datapath. It accepts one frame of 24-bit RGB pixels from an upstream source over a valid/ready handshake and feeds them to the window generator's pixel/valid input. It then injects flush pixels so the final row of windows emerges, and tags every emitted window with its centre coordinates and a border flag. It sits between the frame reader and the window generator and signals frame completion to the dehazing pipeline controller.

## Interface
- IMG_W, 640, frame width in pixels (>=3)
- IMG_H, 480, frame height in pixels (>=3)
- DRAIN_TIMEOUT, 4096, idle-cycle limit in DRAIN; used only with WSC_TIMEOUT_EN

- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin frame; sampled only in IDLE
- busy  output  1  high in FEED/FLUSH/DRAIN
- done  output  1  one-cycle pulse at frame end
- frame_err  output  1  sticky error; cleared by rst or accepted start
- s_pixel  input  24  upstream pixel
- s_valid  input  1  upstream pixel valid
- s_ready  output  1  controller accepts pixel
- wg_pixel  output  24  pixel to window generator
- wg_valid  output  1  pixel valid to window generator
- wg_out_valid  input  1  window generator output_is_valid
- win_valid  output  1  tagged window valid (mirrors wg_out_valid when counted)
- win_col  output  $clog2(IMG_W)  centre column
- win_row  output  $clog2(IMG_H)  centre row
- win_border  output  1  centre on frame edge

## Operation
- States: IDLE, FEED, FLUSH, DRAIN.
- IDLE: s_ready=0, wg_valid=0. start=1 -> FEED; clears in_cnt, flush_cnt, win_cnt and frame_err.
- FEED: s_ready=1 (combinational, state==FEED). Each s_valid&&s_ready handshake increments in_cnt and registers s_pixel into wg_pixel with wg_valid=1. Cycles without a handshake drive wg_valid=0. When the handshake makes in_cnt reach IMG_W*IMG_H -> FLUSH.
- FLUSH: s_ready=0. Drives wg_pixel=0 and wg_valid=1 for exactly IMG_W+1 consecutive cycles, then -> DRAIN.
- DRAIN: wg_valid=0. Waits until win_cnt==IMG_W*IMG_H, then pulses done and -> IDLE.
- Window tagging: in FEED/FLUSH/DRAIN, each wg_out_valid with win_cnt<IMG_W*IMG_H registers win_valid=1, win_col=win_cnt mod IMG_W and win_row=win_cnt div IMG_W. Column and row are kept as wrap counters, with no divider. win_cnt then increments.
- win_border = (col==0)|(col==IMG_W-1)|(row==0)|(row==IMG_H-1), registered with win_col/win_row.
- Errors (frame_err set, no state change): wg_out_valid in IDLE; wg_out_valid with win_cnt already IMG_W*IMG_H. These surplus windows produce win_valid=0.
- Counter widths: in_cnt and win_cnt are $clog2(IMG_W*IMG_H+1); flush_cnt is $clog2(IMG_W+2). No wrap is permitted on any counter.

## Timing
- Reset values: all outputs 0; state IDLE; all counters 0.
- start -> busy: busy=1 the cycle after start is sampled.
- Pixel latency: handshake at cycle N -> wg_pixel/wg_valid at N+1.
- Window tag latency: wg_out_valid at cycle N -> win_valid/win_col/win_row/win_border at N+1.
- Last FEED handshake at N -> FLUSH at N+1. First flush pixel on wg_valid at N+2.
- done asserts the cycle after the final counted wg_out_valid. busy=0 in that same cycle.
- start asserted while busy is ignored. start coincident with done is ignored; it must be reissued in IDLE.
- wg_out_valid may arrive during FEED/FLUSH and is counted normally.
- Reset mid-frame: everything returns immediately to reset values. The window generator is not flushed, so its stale outputs then set frame_err.

## Configuration
- WSC_TIMEOUT_EN defined: a DRAIN watchdog counts consecutive cycles without wg_out_valid. When it reaches DRAIN_TIMEOUT, it sets frame_err, pulses done and -> IDLE.
- WSC_TIMEOUT_EN undefined: no watchdog. DRAIN waits indefinitely, and the DRAIN_TIMEOUT parameter is unused.

## Test plan
- IMG_W=4, IMG_H=3; start, continuous s_valid with pixels 1..12 -> wg_valid carries 1..12 then 5 zero pixels. Model returns 12 windows -> tags (0,0)..(3,2) with border=1 except (1,1),(2,1). done 1 cycle after 12th window; frame_err=0.
- Same frame, s_valid toggled every other cycle -> wg_valid gaps match the handshake gaps. Pixel order is preserved and in_cnt stops at 12.
- Model emits 13 windows -> 13th gives win_valid=0 and frame_err=1. frame_err stays set until the next accepted start.
- rst asserted after 6 FEED handshakes -> outputs 0, state IDLE. A new start runs a full clean frame.
- start pulsed during FLUSH -> ignored; frame completes with a single done.
- With WSC_TIMEOUT_EN and DRAIN_TIMEOUT=16, model stops at 10 windows -> done and frame_err 16 cycles after the last window; state IDLE.
